// File: rtl/shift_add_multiplier.sv
// Sequential radix-2 unsigned shift-add multiplier with valid/ready handshake on both sides.
// One WIDTH+1-bit adder per cycle. The 2*WIDTH product is ready WIDTH cycles after accept.
module shift_add_multiplier #(
  parameter int unsigned WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] acc, multiplicand, multiplier;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   sum;
  logic             last;

  assign last = (count == CW'(WIDTH - 1));

  // The carry-out is kept in sum[WIDTH], so no bit of the partial product is lost.
  always_comb begin
    sum = {1'b0, acc} + (multiplier[0] ? {1'b0, multiplicand} : {(WIDTH+1){1'b0}});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last)      state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == HOLD);
    busy      = (state != IDLE);
  end

  // {acc,multiplier} shifts right as one 2*WIDTH register; the low product bits migrate into multiplier.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc          <= '0;
      multiplicand <= '0;
      multiplier   <= '0;
      count        <= '0;
      product      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            multiplicand <= a;
            multiplier   <= b;
            acc          <= '0;
            count        <= '0;
          end
        end
        RUN: begin
          acc        <= sum[WIDTH:1];
          multiplier <= {sum[0], multiplier[WIDTH-1:1]};
          count      <= count + CW'(1);
          if (last) product <= {sum, multiplier[WIDTH-1:1]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: a directed vector table at WIDTH=8 and random operand pairs at WIDTH=128.
// Each product is compared with plain a*b arithmetic done in the bench.
module tb_shift_add_multiplier;

  logic clk = 1'b0;
  logic reset;

  logic         iv8, ir8, ov8, or8, busy8;
  logic [7:0]   a8, b8;
  logic [15:0]  p8;

  logic         iv128, ir128, ov128, or128, busy128;
  logic [127:0] a128, b128;
  logic [255:0] p128;

  int n_checks = 0;
  int n_fail   = 0;

  shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .product(p8), .busy(busy8)
  );

  shift_add_multiplier #(.WIDTH(128)) dut128 (
    .clk(clk), .reset(reset), .in_valid(iv128), .in_ready(ir128), .a(a128), .b(b128),
    .out_valid(ov128), .out_ready(or128), .product(p128), .busy(busy128)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
    $fatal(1);
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    int          hold;
    bit          disturb;
    string       name;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input vec_t v);
    int cyc;
    cyc = 0;
    while (!ir8 && cyc < 50) begin tick(); cyc++; end
    check({v.name, " ready_before"}, 256'(ir8), 256'(1));
    a8 = v.a; b8 = v.b; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    check({v.name, " busy_after_accept"}, 256'(busy8), 256'(1));
    check({v.name, " in_ready_in_run"}, 256'(ir8), 256'(0));
    cyc = 0;
    while (!ov8 && cyc < 40) begin
      if (v.disturb) begin
        iv8 = ~iv8;
        a8  = 8'($urandom);
        b8  = 8'($urandom);
      end
      tick();
      cyc++;
    end
    iv8 = 1'b0;
    check({v.name, " latency"}, 256'(cyc), 256'(8));
    check({v.name, " product"}, 256'(p8), 256'(v.p));
    for (int i = 0; i < v.hold; i++) begin
      iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); or8 = 1'b0;
      tick();
      check({v.name, " hold_valid"}, 256'(ov8), 256'(1));
      check({v.name, " hold_product"}, 256'(p8), 256'(v.p));
      check({v.name, " hold_in_ready"}, 256'(ir8), 256'(0));
    end
    // in_valid is high on the release edge too: it must not be accepted from HOLD.
    iv8 = 1'b1; or8 = 1'b1;
    tick();
    iv8 = 1'b0; or8 = 1'b0;
    check({v.name, " valid_dropped"}, 256'(ov8), 256'(0));
    check({v.name, " idle_in_ready"}, 256'(ir8), 256'(1));
    check({v.name, " idle_busy"}, 256'(busy8), 256'(0));
  endtask

  task automatic run128(input logic [127:0] x, input logic [127:0] y, input string name);
    logic [255:0] exp;
    int           cyc;
    bit           take;
    exp = 256'(x) * 256'(y);
    cyc = 0;
    while (!ir128 && cyc < 50) begin tick(); cyc++; end
    a128 = x; b128 = y; iv128 = 1'b1;
    tick();
    iv128 = 1'b0;
    a128 = {$urandom, $urandom, $urandom, $urandom};
    b128 = {$urandom, $urandom, $urandom, $urandom};
    cyc = 0;
    while (!ov128 && cyc < 200) begin tick(); cyc++; end
    check({name, " latency"}, 256'(cyc), 256'(128));
    check({name, " product"}, p128, exp);
    cyc = 0;
    do begin
      take  = ($urandom_range(0, 2) == 0) || (cyc >= 20);
      or128 = take;
      tick();
      cyc++;
      if (!take) check({name, " hold_product"}, p128, exp);
    end while (!take);
    or128 = 1'b0;
    check({name, " released"}, 256'(ov128), 256'(0));
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'd255, 8'd255, 16'hFE01, 0, 1'b0, "max_255x255"};
    vecs[1] = '{8'd0,   8'd200, 16'd0,    0, 1'b0, "zero_a"};
    vecs[2] = '{8'd13,  8'd1,   16'd13,   0, 1'b0, "b_one"};
    vecs[3] = '{8'd37,  8'd5,   16'd185,  5, 1'b0, "backpressure"};
    vecs[4] = '{8'd11,  8'd17,  16'd187,  0, 1'b1, "run_disturb"};
    vecs[5] = '{8'd1,   8'd0,   16'd0,    0, 1'b0, "zero_b"};
    vecs[6] = '{8'd128, 8'd2,   16'd256,  0, 1'b0, "carry_into_hi"};
    vecs[7] = '{8'd200, 8'd3,   16'd600,  2, 1'b0, "hold_two"};

    reset = 1'b1;
    iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0;
    iv128 = 1'b0; or128 = 1'b0; a128 = '0; b128 = '0;
    tick();
    tick();
    check("reset in_ready", 256'(ir8), 256'(1));
    check("reset out_valid", 256'(ov8), 256'(0));
    check("reset busy", 256'(busy8), 256'(0));
    check("reset product", 256'(p8), 256'(0));
    check("reset product128", p128, 256'(0));
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run8(vecs[i]);

    // Reset in the middle of RUN, with count at 4.
    a8 = 8'd100; b8 = 8'd100; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    repeat (4) tick();
    check("mid_run busy", 256'(busy8), 256'(1));
    reset = 1'b1;
    #1;
    check("mid_run_reset out_valid", 256'(ov8), 256'(0));
    check("mid_run_reset in_ready", 256'(ir8), 256'(1));
    check("mid_run_reset busy", 256'(busy8), 256'(0));
    check("mid_run_reset product", 256'(p8), 256'(0));
    tick();
    reset = 1'b0;
    tick();
    run8('{8'd7, 8'd9, 16'd63, 0, 1'b0, "after_reset_7x9"});

    run128('1, '1, "w128_max");
    run128('0, '1, "w128_zero");
    run128(128'd1, '1, "w128_one");
    for (int i = 0; i < 200; i++) begin
      run128({$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, "w128_rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
